rename_ckpt: RTL and testbench
==============================

Name: rename_ckpt

Overview:
Parametrised register-rename stage with checkpointed recovery. Maps up to RWD logical-register instructions per cycle onto physical registers. Resolves intra-group dependencies and keeps a circular pool of map-table/free-list checkpoints for single-cycle branch recovery. A multi-cycle walk FSM undoes speculative mappings on exception flush. Sits between decode and dispatch and returns freed registers from commit.

Parameters:
RWD, 4, rename width (slots per group)
CWD, 4, commit/release width
WKWD, 2, walk-back entries consumed per cycle
LRNUM, 64, logical registers; index 0 is hardwired zero
PRNUM, 96, physical registers; must be greater than LRNUM
CKNUM, 8, checkpoint slots (power of 2)
Derived: LW=$clog2(LRNUM), PW=$clog2(PRNUM), CW=$clog2(CKNUM).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  RWD  slot valid; contiguous from slot 0
in_wen  in  RWD  slot writes rd
in_ckpt  in  RWD  slot is a branch needing a checkpoint
in_rd/in_rs1/in_rs2  in  RWD*LW  logical register numbers
in_ready  out  1  group accepted this cycle (all-or-nothing)
out_valid  out  RWD  renamed slot valid
out_prd/out_oprd/out_prs1/out_prs2  out  RWD*PW  new dest, previous dest mapping, sources
out_ckid  out  RWD*CW  checkpoint id for branch slots
out_ready  in  1  downstream accepts the output register
com_valid  in  CWD  commit frees com_oprd
com_oprd  in  CWD*PW  register to free
com_ckrel  in  1  release oldest checkpoint
redir  in  1  branch mispredict
redir_ckid  in  CW  checkpoint to restore
flush  in  1  exception flush; enter walk
walk_valid  in  WKWD  walk entries, youngest first
walk_lrd  in  WKWD*LW
walk_prd/walk_oprd  in  WKWD*PW
walk_done  in  1  walk finished
busy  out  1  FSM in WALK
free_cnt  out  PW+1  free physical registers

Behaviour:
- Reset (async):
  - mt[i]=i.
  - pregs LRNUM..PRNUM-1 free; free_cnt=PRNUM-LRNUM.
  - checkpoint head=tail=0, count 0.
  - out_valid=0, busy=0, FSM=RUN.
- Preg 0 is never allocated or freed. A slot with wen&&rd==0 gets prd=0 and oprd=0, and does not consume a register.
- Allocation: lowest-index free registers, assigned in slot order. needed = count of valid slots with wen&&rd!=0.
- in_ready=1 only when all of the following hold:
  - FSM=RUN.
  - No redir or flush this cycle.
  - Output register empty, or out_ready=1.
  - free_cnt >= needed.
  - Free checkpoints >= number of in_ckpt slots.
- fire = in_ready & in_valid[0]. Output register loads on fire; latency 1 cycle. Outputs hold while out_valid!=0 and out_ready=0.
- Intra-group bypass: slot i's rs1/rs2/oprd take the youngest earlier slot j<i writing the same rd; otherwise mt.
- Checkpoints:
  - Allocated at tail, circular.
  - Snapshot = map table and free list after the branch slot's own writes, excluding later slots.
  - out_ckid = allocated id.
  - com_ckrel advances head; ignored when count=0.
- Commit frees set the bit in the live free list and in every checkpoint free list.
- redir:
  - Next cycle: mt and free list take checkpoint redir_ckid; tail=redir_ckid+1 (younger checkpoints discarded).
  - out_valid cleared.
  - Same-cycle commit frees are still applied.
  - fire is suppressed.
- flush:
  - FSM RUN→WALK; out_valid cleared; all checkpoints discarded (tail=head).
  - In WALK, each walk_valid entry k, processed in order k=0..WKWD-1: mt[walk_lrd]=walk_oprd, walk_prd freed.
  - walk_done → RUN next cycle.
  - redir is ignored in WALK.
  - busy=1 in WALK.
- free_cnt is updated every cycle: +frees −allocs, saturating at PRNUM-1.

Test Plan:
- Reset, group rd=1,2,3,4 wen=1 → next cycle prd=64,65,66,67, oprd=1,2,3,4; free_cnt=28.
- Slot0 rd=5 wen, slot1 rs1=5, slot2 rd=5 wen, slot3 rs2=5 → prs1[1]=64, oprd[2]=64, prs2[3]=65.
- Eight 4-write groups → free_cnt=0, ninth group in_ready=0. com_valid=4'hF oprd=1..4 → in_ready=1 next cycle; new prd=1,2,3,4.
- Branch in slot0 (ckid 0), next group rd=1→prd 65; redir ckid=0 → mt[1]=64, free_cnt back to pre-second-group value. Eight unreleased branches → in_ready=0 until com_ckrel.
- After 6 renames, flush; walk 3 cycles of 2 entries with oprd restore, then walk_done → busy 1 for 3 cycles, mt identity-restored, free_cnt=32.
- Assert rst mid-WALK asynchronously → busy=0, out_valid=0, free_cnt=32 immediately.

Source files
------------

// File: rtl/rename_ckpt.sv
// rename_ckpt: register rename stage. Maps up to RWD logical destinations per
// cycle onto physical registers, keeps a circular pool of map/free-list
// checkpoints for one-cycle branch recovery, and walks back speculative
// mappings after an exception flush.
module rename_ckpt #(
    parameter int RWD   = 4,
    parameter int CWD   = 4,
    parameter int WKWD  = 2,
    parameter int LRNUM = 64,
    parameter int PRNUM = 96,
    parameter int CKNUM = 8,
    parameter int LW    = $clog2(LRNUM),
    parameter int PW    = $clog2(PRNUM),
    parameter int CW    = $clog2(CKNUM)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [RWD-1:0]           in_valid,
    input  logic [RWD-1:0]           in_wen,
    input  logic [RWD-1:0]           in_ckpt,
    input  logic [RWD-1:0][LW-1:0]   in_rd,
    input  logic [RWD-1:0][LW-1:0]   in_rs1,
    input  logic [RWD-1:0][LW-1:0]   in_rs2,
    output logic                     in_ready,
    output logic [RWD-1:0]           out_valid,
    output logic [RWD-1:0][PW-1:0]   out_prd,
    output logic [RWD-1:0][PW-1:0]   out_oprd,
    output logic [RWD-1:0][PW-1:0]   out_prs1,
    output logic [RWD-1:0][PW-1:0]   out_prs2,
    output logic [RWD-1:0][CW-1:0]   out_ckid,
    input  logic                     out_ready,
    input  logic [CWD-1:0]           com_valid,
    input  logic [CWD-1:0][PW-1:0]   com_oprd,
    input  logic                     com_ckrel,
    input  logic                     redir,
    input  logic [CW-1:0]            redir_ckid,
    input  logic                     flush,
    input  logic [WKWD-1:0]          walk_valid,
    input  logic [WKWD-1:0][LW-1:0]  walk_lrd,
    input  logic [WKWD-1:0][PW-1:0]  walk_prd,
    input  logic [WKWD-1:0][PW-1:0]  walk_oprd,
    input  logic                     walk_done,
    output logic                     busy,
    output logic [PW:0]              free_cnt
);
    typedef enum logic {RUN, WALK} state_t;
    state_t state, state_nxt;

    logic [LRNUM-1:0][PW-1:0]            mt, mt_nxt, mt_w;
    logic [PRNUM-1:0]                    fl, fl_nxt, fl_w, cmask;
    logic [CKNUM-1:0][LRNUM-1:0][PW-1:0] ck_mt;
    logic [CKNUM-1:0][PRNUM-1:0]         ck_fl;
    logic [CW-1:0]                       ck_head, ck_tail, head_nxt;
    logic [CW:0]                         ck_cnt, nck;
    logic [PW:0]                         needed, fcnt_nxt;
    logic [RWD-1:0][LRNUM-1:0][PW-1:0]   snap_mt;
    logic [RWD-1:0][PRNUM-1:0]           snap_fl;
    logic [RWD-1:0][PW-1:0]              r_prd, r_oprd, r_prs1, r_prs2;
    logic [RWD-1:0][CW-1:0]              r_ckid;
    logic                                fire, rel;

    // Walk the group slot by slot over a running map/free list: this gives the
    // intra-group bypass, in-order lowest-free allocation and per-branch snapshots.
    always_comb begin
        logic found;
        found   = 1'b0;
        mt_w    = mt;
        fl_w    = fl;
        needed  = '0;
        nck     = '0;
        snap_mt = '0;
        snap_fl = '0;
        r_prd   = '0;
        r_oprd  = '0;
        r_prs1  = '0;
        r_prs2  = '0;
        r_ckid  = '0;
        for (int i = 0; i < RWD; i++) begin
            r_prs1[i] = mt_w[in_rs1[i]];
            r_prs2[i] = mt_w[in_rs2[i]];
            if (in_valid[i] && in_wen[i] && in_rd[i] != '0) begin
                r_oprd[i] = mt_w[in_rd[i]];
                found = 1'b0;
                for (int p = 1; p < PRNUM; p++) begin
                    if (!found && fl_w[p]) begin
                        r_prd[i] = PW'(p);
                        found    = 1'b1;
                    end
                end
                fl_w[r_prd[i]]  = 1'b0;
                mt_w[in_rd[i]]  = r_prd[i];
                needed          = needed + (PW+1)'(1);
            end
            if (in_valid[i] && in_ckpt[i]) begin
                r_ckid[i] = ck_tail + nck[CW-1:0];
                nck       = nck + (CW+1)'(1);
            end
            snap_mt[i] = mt_w;
            snap_fl[i] = fl_w;
        end
    end

    // Registers returned by commit this cycle; preg 0 is never freed.
    always_comb begin
        cmask = '0;
        for (int k = 0; k < CWD; k++)
            if (com_valid[k] && com_oprd[k] != '0) cmask[com_oprd[k]] = 1'b1;
    end

    // Accept a whole group only when every resource for it is available.
    always_comb begin
        in_ready = (state == RUN) && !redir && !flush &&
                   (out_valid == '0 || out_ready) &&
                   (free_cnt >= needed) &&
                   (((CW+1)'(CKNUM) - ck_cnt) >= nck);
        fire     = in_ready && in_valid[0];
        busy     = (state == WALK);
        rel      = com_ckrel && (ck_cnt != '0);
        head_nxt = ck_head + CW'(rel);
    end

    // Next map table, free list and FSM state.
    always_comb begin
        state_nxt = state;
        mt_nxt    = mt;
        fl_nxt    = fl;
        case (state)
            RUN: begin
                if (flush) begin
                    state_nxt = WALK;
                end else if (redir) begin
                    mt_nxt = ck_mt[redir_ckid];
                    fl_nxt = ck_fl[redir_ckid];
                end else if (fire) begin
                    mt_nxt = mt_w;
                    fl_nxt = fl_w;
                end
            end
            WALK: begin
                for (int k = 0; k < WKWD; k++) begin
                    if (walk_valid[k] && walk_lrd[k] != '0) begin
                        mt_nxt[walk_lrd[k]] = walk_oprd[k];
                        if (walk_prd[k] != '0) fl_nxt[walk_prd[k]] = 1'b1;
                    end
                end
                if (walk_done) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
        fl_nxt = fl_nxt | cmask;
    end

    // Free count tracks the population of the next free list.
    always_comb begin
        fcnt_nxt = '0;
        for (int p = 0; p < PRNUM; p++) fcnt_nxt = fcnt_nxt + (PW+1)'(fl_nxt[p]);
    end

    // Live map table, free list, free count and FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            for (int i = 0; i < LRNUM; i++) mt[i] <= PW'(i);
            for (int p = 0; p < PRNUM; p++) fl[p] <= (p >= LRNUM);
            free_cnt <= (PW+1)'(PRNUM - LRNUM);
        end else begin
            state    <= state_nxt;
            mt       <= mt_nxt;
            fl       <= fl_nxt;
            free_cnt <= fcnt_nxt;
        end
    end

    // Checkpoint pool: commit frees reach every snapshot; redir trims younger ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ck_mt   <= '0;
            ck_fl   <= '0;
            ck_head <= '0;
            ck_tail <= '0;
            ck_cnt  <= '0;
        end else begin
            ck_head <= head_nxt;
            for (int c = 0; c < CKNUM; c++) ck_fl[c] <= ck_fl[c] | cmask;
            if (flush) begin
                ck_tail <= head_nxt;
                ck_cnt  <= '0;
            end else if (state == RUN && redir) begin
                ck_tail <= redir_ckid + CW'(1);
                ck_cnt  <= {1'b0, CW'(redir_ckid - ck_head)} + (CW+1)'(1) - (CW+1)'(rel);
            end else if (fire) begin
                ck_tail <= ck_tail + nck[CW-1:0];
                ck_cnt  <= ck_cnt + nck - (CW+1)'(rel);
                for (int i = 0; i < RWD; i++) begin
                    if (in_valid[i] && in_ckpt[i]) begin
                        ck_mt[r_ckid[i]] <= snap_mt[i];
                        ck_fl[r_ckid[i]] <= snap_fl[i] | cmask;
                    end
                end
            end else begin
                ck_cnt <= ck_cnt - (CW+1)'(rel);
            end
        end
    end

    // Output register toward dispatch; recovery kills whatever it holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= '0;
            out_prd   <= '0;
            out_oprd  <= '0;
            out_prs1  <= '0;
            out_prs2  <= '0;
            out_ckid  <= '0;
        end else if (flush || (redir && state == RUN)) begin
            out_valid <= '0;
        end else if (fire) begin
            out_valid <= in_valid;
            out_prd   <= r_prd;
            out_oprd  <= r_oprd;
            out_prs1  <= r_prs1;
            out_prs2  <= r_prs2;
            out_ckid  <= r_ckid;
        end else if (out_ready) begin
            out_valid <= '0;
        end
    end
endmodule

// File: tb/tb_rename_ckpt.sv
// tb_rename_ckpt: directed vectors with hand-computed expectations for rename_ckpt.
module tb_rename_ckpt;
    localparam int RWD = 4, CWD = 4, WKWD = 2, LRNUM = 64, PRNUM = 96, CKNUM = 8;
    localparam int LW = 6, PW = 7, CW = 3;

    logic clk = 1'b0;
    logic rst;
    logic [RWD-1:0]          in_valid, in_wen, in_ckpt;
    logic [RWD-1:0][LW-1:0]  in_rd, in_rs1, in_rs2;
    logic                    in_ready;
    logic [RWD-1:0]          out_valid;
    logic [RWD-1:0][PW-1:0]  out_prd, out_oprd, out_prs1, out_prs2;
    logic [RWD-1:0][CW-1:0]  out_ckid;
    logic                    out_ready;
    logic [CWD-1:0]          com_valid;
    logic [CWD-1:0][PW-1:0]  com_oprd;
    logic                    com_ckrel, redir, flush, walk_done, busy;
    logic [CW-1:0]           redir_ckid;
    logic [WKWD-1:0]         walk_valid;
    logic [WKWD-1:0][LW-1:0] walk_lrd;
    logic [WKWD-1:0][PW-1:0] walk_prd, walk_oprd;
    logic [PW:0]             free_cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rename_ckpt #(.RWD(RWD), .CWD(CWD), .WKWD(WKWD), .LRNUM(LRNUM), .PRNUM(PRNUM), .CKNUM(CKNUM)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_wen(in_wen), .in_ckpt(in_ckpt),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_ready(in_ready),
        .out_valid(out_valid), .out_prd(out_prd), .out_oprd(out_oprd),
        .out_prs1(out_prs1), .out_prs2(out_prs2), .out_ckid(out_ckid), .out_ready(out_ready),
        .com_valid(com_valid), .com_oprd(com_oprd), .com_ckrel(com_ckrel),
        .redir(redir), .redir_ckid(redir_ckid), .flush(flush),
        .walk_valid(walk_valid), .walk_lrd(walk_lrd), .walk_prd(walk_prd),
        .walk_oprd(walk_oprd), .walk_done(walk_done), .busy(busy), .free_cnt(free_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic clr();
        in_valid = '0; in_wen = '0; in_ckpt = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        com_valid = '0; com_oprd = '0; com_ckrel = 1'b0;
        redir = 1'b0; redir_ckid = '0; flush = 1'b0;
        walk_valid = '0; walk_lrd = '0; walk_prd = '0; walk_oprd = '0; walk_done = 1'b0;
    endtask

    task automatic slot(input int i, input logic w, input logic ck, input int rd, input int rs1, input int rs2);
        in_valid[i] = 1'b1; in_wen[i] = w; in_ckpt[i] = ck;
        in_rd[i] = LW'(rd); in_rs1[i] = LW'(rs1); in_rs2[i] = LW'(rs2);
    endtask

    task automatic walk(input int k, input int lrd, input int prd, input int oprd);
        walk_valid[k] = 1'b1; walk_lrd[k] = LW'(lrd);
        walk_prd[k] = PW'(prd); walk_oprd[k] = PW'(oprd);
    endtask

    // one clock, then sample 1 time unit after the edge
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        clr(); rst = 1'b1; #2; rst = 1'b0; cyc();
    endtask

    task automatic grp4();
        for (int i = 0; i < 4; i++) slot(i, 1'b1, 1'b0, i + 1, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr(); out_ready = 1'b1; rst = 1'b1;
        #12 rst = 1'b0;
        cyc();
        chk("rst_free_cnt", free_cnt, 32);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);

        // basic group rd=1..4
        grp4(); cyc(); clr();
        chk("t1_valid", out_valid, 4'hF);
        chk("t1_prd", out_prd, {7'd67, 7'd66, 7'd65, 7'd64});
        chk("t1_oprd", out_oprd, {7'd4, 7'd3, 7'd2, 7'd1});
        chk("t1_free_cnt", free_cnt, 28);

        // intra-group bypass
        do_reset();
        slot(0, 1, 0, 5, 0, 0); slot(1, 0, 0, 0, 5, 0);
        slot(2, 1, 0, 5, 0, 0); slot(3, 0, 0, 0, 0, 5);
        cyc(); clr();
        chk("t2_prd", out_prd, {7'd0, 7'd65, 7'd0, 7'd64});
        chk("t2_oprd", out_oprd, {7'd0, 7'd64, 7'd0, 7'd5});
        chk("t2_prs1", out_prs1, {7'd0, 7'd0, 7'd64, 7'd0});
        chk("t2_prs2", out_prs2, {7'd65, 7'd0, 7'd0, 7'd0});
        chk("t2_free_cnt", free_cnt, 30);

        // exhaust free list, then refill from commit
        do_reset();
        for (int g = 0; g < 8; g++) begin
            grp4(); cyc(); clr();
        end
        chk("t3_free_cnt0", free_cnt, 0);
        chk("t3_last_prd", out_prd, {7'd95, 7'd94, 7'd93, 7'd92});
        grp4(); #1;
        chk("t3_stall", in_ready, 0);
        com_valid = 4'hF; com_oprd = {7'd4, 7'd3, 7'd2, 7'd1};
        cyc(); com_valid = '0;
        chk("t3_free_cnt4", free_cnt, 4);
        chk("t3_ready", in_ready, 1);
        cyc(); clr();
        chk("t3_prd", out_prd, {7'd4, 7'd3, 7'd2, 7'd1});
        chk("t3_oprd", out_oprd, {7'd95, 7'd94, 7'd93, 7'd92});
        chk("t3_free_cnt_end", free_cnt, 0);

        // branch checkpoint and redirect
        do_reset();
        slot(0, 1, 1, 1, 0, 0); cyc(); clr();
        chk("t4_ckid0", out_ckid, 0);
        chk("t4_br_prd", out_prd, 64);
        chk("t4_free31", free_cnt, 31);
        slot(0, 1, 0, 1, 0, 0); cyc(); clr();
        chk("t4_prd65", out_prd, 65);
        chk("t4_oprd64", out_oprd, 64);
        chk("t4_free30", free_cnt, 30);
        redir = 1'b1; redir_ckid = 3'd0; #1;
        chk("t4_redir_noready", in_ready, 0);
        cyc(); clr();
        chk("t4_redir_valid", out_valid, 0);
        chk("t4_redir_free", free_cnt, 31);
        slot(0, 1, 0, 2, 1, 0); cyc(); clr();
        chk("t4_mt1", out_prs1, 64);
        chk("t4_realloc", out_prd, 65);
        chk("t4_oprd2", out_oprd, 2);
        for (int b = 1; b < 8; b++) begin
            slot(0, 0, 1, 0, 0, 0); cyc(); clr();
            chk("t4_ckid_seq", out_ckid, b);
        end
        slot(0, 0, 1, 0, 0, 0); #1;
        chk("t4_ck_full", in_ready, 0);
        com_ckrel = 1'b1; cyc(); com_ckrel = 1'b0;
        chk("t4_ck_rel_ready", in_ready, 1);
        cyc(); clr();
        chk("t4_ckid_wrap", out_ckid, 0);

        // flush and walk back six mappings
        do_reset();
        grp4(); cyc(); clr();
        slot(0, 1, 0, 5, 0, 0); slot(1, 1, 0, 6, 0, 0); cyc(); clr();
        chk("t5_free26", free_cnt, 26);
        flush = 1'b1; cyc(); clr();
        chk("t5_busy_a", busy, 1);
        chk("t5_flush_valid", out_valid, 0);
        walk(0, 6, 69, 6); walk(1, 5, 68, 5); cyc(); clr();
        chk("t5_busy_b", busy, 1);
        walk(0, 4, 67, 4); walk(1, 3, 66, 3); cyc(); clr();
        chk("t5_busy_c", busy, 1);
        walk(0, 2, 65, 2); walk(1, 1, 64, 1); walk_done = 1'b1; cyc(); clr();
        chk("t5_busy_done", busy, 0);
        chk("t5_free32", free_cnt, 32);
        slot(0, 1, 0, 7, 1, 5); slot(1, 0, 0, 0, 2, 6);
        slot(2, 0, 0, 0, 3, 0); slot(3, 0, 0, 0, 4, 0); #1;
        chk("t5_ready", in_ready, 1);
        cyc(); clr();
        chk("t5_prs1", out_prs1, {7'd4, 7'd3, 7'd2, 7'd1});
        chk("t5_prs2", out_prs2, {7'd0, 7'd0, 7'd6, 7'd5});
        chk("t5_prd", out_prd, 64);

        // async reset in the middle of a walk
        grp4(); cyc(); clr();
        flush = 1'b1; cyc(); clr();
        chk("t6_busy", busy, 1);
        #2 rst = 1'b1; #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_free", free_cnt, 32);
        #1 rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
